// File: rtl/oc8051_cxrom_fetch_if.sv
// Core/ROM bus for the 8051 code-ROM fetch queue.
// The master side plays the core and the combinational ROM.
interface oc8051_cxrom_fetch_if;
    logic        fetch_en;
    logic        pc_ld;
    logic [15:0] pc_new;
    logic [1:0]  consume;
    logic [15:0] cxrom_addr;
    logic [31:0] cxrom_data_in;
    logic [15:0] fetch_pc;
    logic [23:0] fetch_data;
    logic [1:0]  fetch_valid;
    logic        fetch_err;

    modport master (
        output fetch_en,
        output pc_ld,
        output pc_new,
        output consume,
        output cxrom_data_in,
        input  cxrom_addr,
        input  fetch_pc,
        input  fetch_data,
        input  fetch_valid,
        input  fetch_err
    );

    modport slave (
        input  fetch_en,
        input  pc_ld,
        input  pc_new,
        input  consume,
        input  cxrom_data_in,
        output cxrom_addr,
        output fetch_pc,
        output fetch_data,
        output fetch_valid,
        output fetch_err
    );
endinterface

// File: rtl/oc8051_cxrom_fetch.sv
// 8-byte instruction prefetch queue fed 4 bytes at a time
// from a combinational code ROM.
module oc8051_cxrom_fetch (
    input logic                     clk,
    input logic                     rst,
    oc8051_cxrom_fetch_if.slave     bus
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  mem_q [8];
    logic [7:0]  mem_d [8];
    logic [2:0]  head_q, head_d;
    logic [3:0]  count_q, count_d;
    logic [15:0] head_pc_q, head_pc_d;
    logic [15:0] fill_addr_q, fill_addr_d;
    logic        err_q, err_d;

    logic [1:0]  valid;
    logic        legal;
    logic [1:0]  take;
    logic [3:0]  left;
    logic        fill;
    logic [2:0]  tail;
    logic [2:0]  widx;
    logic [2:0]  ridx;

    always_comb begin
        valid = (count_q >= 4'd3) ? 2'd3 : count_q[1:0];
        legal = (bus.consume <= valid);
        take  = legal ? bus.consume : 2'd0;
        left  = count_q - {2'b00, take};
        fill  = (state_q == RUN) && (left <= 4'd4);
        // count of 8 maps to tail == head, but fill is then impossible
        tail  = head_q + count_q[2:0];
        widx  = 3'd0;

        state_d     = bus.fetch_en ? RUN : IDLE;
        mem_d       = mem_q;
        head_d      = head_q;
        count_d     = count_q;
        head_pc_d   = head_pc_q;
        fill_addr_d = fill_addr_q;
        err_d       = 1'b0;

        if (bus.pc_ld) begin
            count_d     = 4'd0;
            head_pc_d   = bus.pc_new;
            fill_addr_d = bus.pc_new;
        end else begin
            err_d     = !legal;
            head_d    = head_q + {1'b0, take};
            head_pc_d = head_pc_q + {14'd0, take};
            count_d   = left;
            if (fill) begin
                for (int i = 0; i < 4; i++) begin
                    widx = tail + 3'(i);
                    mem_d[widx] = bus.cxrom_data_in[8*i +: 8];
                end
                fill_addr_d = fill_addr_q + 16'd4;
                count_d     = left + 4'd4;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            head_q      <= 3'd0;
            count_q     <= 4'd0;
            head_pc_q   <= 16'd0;
            fill_addr_q <= 16'd0;
            err_q       <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= 8'd0;
            end
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            count_q     <= count_d;
            head_pc_q   <= head_pc_d;
            fill_addr_q <= fill_addr_d;
            err_q       <= err_d;
            mem_q       <= mem_d;
        end
    end

    // bytes past the valid count read as zero
    always_comb begin
        bus.fetch_data = 24'd0;
        ridx = 3'd0;
        for (int i = 0; i < 3; i++) begin
            ridx = head_q + 3'(i);
            if (valid > 2'(i)) begin
                bus.fetch_data[8*i +: 8] = mem_q[ridx];
            end
        end
    end

    assign bus.cxrom_addr  = fill_addr_q;
    assign bus.fetch_pc    = head_pc_q;
    assign bus.fetch_valid = valid;
    assign bus.fetch_err   = err_q;

endmodule

// File: tb/tb_oc8051_cxrom_fetch.sv
// Bench for the fetch queue: byte-queue model, directed
// corner cases and a randomized run.
module tb_oc8051_cxrom_fetch;

    logic clk = 1'b0;
    logic rst;
    logic [7:0] salt;

    always #5 clk = ~clk;

    oc8051_cxrom_fetch_if bus ();

    oc8051_cxrom_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [7:0] rom(input logic [15:0] a);
        logic [7:0] m;
        m = a[15:8] * salt;
        return a[7:0] ^ m;
    endfunction

    assign bus.cxrom_data_in = {rom(bus.cxrom_addr + 16'd3),
                                rom(bus.cxrom_addr + 16'd2),
                                rom(bus.cxrom_addr + 16'd1),
                                rom(bus.cxrom_addr)};

    logic [7:0]  q [$];
    logic [15:0] m_pc;
    logic [15:0] m_fill;
    bit          m_run;
    bit          m_err;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mreset();
        q.delete();
        m_pc   = 16'd0;
        m_fill = 16'd0;
        m_run  = 1'b0;
        m_err  = 1'b0;
    endtask

    function automatic int mvalid();
        return (q.size() >= 3) ? 3 : q.size();
    endfunction

    task automatic mstep();
        int c;
        if (rst) begin
            mreset();
            return;
        end
        c = int'(bus.consume);
        if (bus.pc_ld) begin
            q.delete();
            m_pc   = bus.pc_new;
            m_fill = bus.pc_new;
            m_err  = 1'b0;
        end else begin
            m_err = (c > mvalid());
            if (!m_err) begin
                repeat (c) void'(q.pop_front());
                m_pc = m_pc + 16'(c);
            end
            if (m_run && q.size() <= 4) begin
                for (int i = 0; i < 4; i++) q.push_back(rom(m_fill + 16'(i)));
                m_fill = m_fill + 16'd4;
            end
        end
        m_run = bus.fetch_en;
    endtask

    task automatic compare();
        logic [23:0] d;
        int v;
        v = mvalid();
        d = 24'd0;
        for (int i = 0; i < 3; i++) if (i < v) d[8*i +: 8] = q[i];
        chk("cxrom_addr", {16'd0, bus.cxrom_addr}, {16'd0, m_fill});
        chk("fetch_pc", {16'd0, bus.fetch_pc}, {16'd0, m_pc});
        chk("fetch_valid", {30'd0, bus.fetch_valid}, v);
        chk("fetch_data", {8'd0, bus.fetch_data}, {8'd0, d});
        chk("fetch_err", {31'd0, bus.fetch_err}, {31'd0, m_err});
    endtask

    task automatic step();
        @(posedge clk);
        mstep();
        #1;
        compare();
    endtask

    task automatic drive(input bit en, input bit ld,
                         input logic [15:0] pc, input logic [1:0] c);
        bus.fetch_en = en;
        bus.pc_ld    = ld;
        bus.pc_new   = pc;
        bus.consume  = c;
    endtask

    initial begin
        rst  = 1'b1;
        salt = 8'd0;
        drive(1'b0, 1'b0, 16'd0, 2'd0);
        mreset();
        #1;
        compare();
        @(posedge clk);
        #1;
        compare();

        // power-up fill from 0 with identity ROM
        rst = 1'b0;
        drive(1'b1, 1'b0, 16'd0, 2'd0);
        step();
        step();
        chk("lit_first_valid", {30'd0, bus.fetch_valid}, 32'd3);
        chk("lit_first_data", {8'd0, bus.fetch_data}, 32'h020100);
        chk("lit_first_pc", {16'd0, bus.fetch_pc}, 32'h0);
        step();
        chk("lit_full_addr", {16'd0, bus.cxrom_addr}, 32'h8);
        step();
        chk("lit_full_hold", {16'd0, bus.cxrom_addr}, 32'h8);

        salt = 8'h3b;

        // steady 3-byte consume from 0x0100
        drive(1'b1, 1'b1, 16'h0100, 2'd0);
        step();
        drive(1'b1, 1'b0, 16'h0, 2'd0);
        chk("lit_ld_valid0", {30'd0, bus.fetch_valid}, 32'd0);
        step();
        drive(1'b1, 1'b0, 16'h0, 2'd3);
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("lit_stream_pc", {16'd0, bus.fetch_pc}, 32'h0100 + 32'(3*k));
            chk("lit_stream_valid", {30'd0, bus.fetch_valid}, 32'd3);
        end

        // pc_ld wins over a simultaneous consume
        drive(1'b1, 1'b1, 16'h1234, 2'd2);
        step();
        drive(1'b1, 1'b0, 16'h0, 2'd0);
        chk("lit_ld_addr", {16'd0, bus.cxrom_addr}, 32'h1234);
        chk("lit_ld_valid", {30'd0, bus.fetch_valid}, 32'd0);
        step();
        chk("lit_ld_pc", {16'd0, bus.fetch_pc}, 32'h1234);
        chk("lit_ld_valid3", {30'd0, bus.fetch_valid}, 32'd3);

        // address wrap at top of memory
        drive(1'b1, 1'b1, 16'hfffc, 2'd0);
        step();
        drive(1'b1, 1'b0, 16'h0, 2'd0);
        chk("lit_wrap_addr0", {16'd0, bus.cxrom_addr}, 32'hfffc);
        step();
        chk("lit_wrap_addr1", {16'd0, bus.cxrom_addr}, 32'h0000);
        chk("lit_wrap_pc0", {16'd0, bus.fetch_pc}, 32'hfffc);
        drive(1'b1, 1'b0, 16'h0, 2'd3);
        step();
        chk("lit_wrap_pc1", {16'd0, bus.fetch_pc}, 32'hffff);
        step();
        chk("lit_wrap_pc2", {16'd0, bus.fetch_pc}, 32'h0002);

        // illegal consume with one byte held while paused
        drive(1'b1, 1'b1, 16'h0200, 2'd0);
        step();
        drive(1'b1, 1'b0, 16'h0, 2'd0);
        step();
        drive(1'b0, 1'b0, 16'h0, 2'd0);
        step();
        drive(1'b0, 1'b0, 16'h0, 2'd3);
        step();
        step();
        drive(1'b0, 1'b0, 16'h0, 2'd1);
        step();
        chk("lit_one_valid", {30'd0, bus.fetch_valid}, 32'd1);
        drive(1'b0, 1'b0, 16'h0, 2'd2);
        step();
        drive(1'b0, 1'b0, 16'h0, 2'd0);
        chk("lit_err_set", {31'd0, bus.fetch_err}, 32'd1);
        chk("lit_err_pc", {16'd0, bus.fetch_pc}, 32'h0207);
        step();
        chk("lit_err_clr", {31'd0, bus.fetch_err}, 32'd0);

        // async reset with six bytes queued
        drive(1'b1, 1'b1, 16'h0500, 2'd0);
        step();
        drive(1'b1, 1'b0, 16'h0, 2'd0);
        step();
        drive(1'b1, 1'b0, 16'h0, 2'd2);
        step();
        drive(1'b1, 1'b0, 16'h0, 2'd0);
        #2;
        rst = 1'b1;
        mreset();
        #1;
        chk("lit_rst_addr", {16'd0, bus.cxrom_addr}, 32'h0);
        chk("lit_rst_pc", {16'd0, bus.fetch_pc}, 32'h0);
        chk("lit_rst_valid", {30'd0, bus.fetch_valid}, 32'd0);
        chk("lit_rst_data", {8'd0, bus.fetch_data}, 32'h0);
        step();
        rst = 1'b0;
        step();
        step();
        chk("lit_refill_addr", {16'd0, bus.cxrom_addr}, 32'h4);
        chk("lit_refill_pc", {16'd0, bus.fetch_pc}, 32'h0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] pc;
            pc = ($urandom_range(0, 3) == 0) ?
                 16'hfff8 + 16'($urandom_range(0, 7)) : 16'($urandom);
            drive($urandom_range(0, 7) != 0,
                  $urandom_range(0, 19) == 0,
                  pc,
                  2'($urandom_range(0, 3)));
            if ($urandom_range(0, 99) == 0) salt = 8'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                mreset();
            end else begin
                rst = 1'b0;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/oc8051_cxrom_fetch.md
OC8051_CXROM_FETCH -- requirements
Module: oc8051_cxrom_fetch

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst  input  1  reset, asynchronous, active-high.
REQ-003: fetch_en  input  1  1 = queue may fill from ROM; 0 = filling paused, queue contents held.
REQ-004: pc_ld  input  1  one-cycle pulse: flush the queue and restart the fetch at pc_new.
REQ-005: pc_new  input  16  target byte address, sampled when pc_ld=1.
REQ-006: consume  input  2  number of bytes (0..3) the core takes from the queue head this cycle.
REQ-007: cxrom_addr  output  16  ROM byte address; the ROM returns bytes addr..addr+3 combinationally in the same cycle.
REQ-008: cxrom_data_in  input  32  ROM word: [7:0]=byte at addr, [15:8]=addr+1, [23:16]=addr+2, [31:24]=addr+3.
REQ-009: fetch_pc  output  16  byte address of the queue head.
REQ-010: fetch_data  output  24  [7:0]=head byte, [15:8]=head+1, [23:16]=head+2; a byte position at or beyond fetch_valid drives 0x00.
REQ-011: fetch_valid  output  2  min(count,3), where count is the number of bytes held in the queue.
REQ-012: fetch_err  output  1  one-cycle pulse flagging an illegal consume request.

Function
REQ-013: The block SHALL hold an 8-byte circular byte queue with head pointer, count (0..8), head_pc and fill_addr registers, all 16-bit addresses wrapping modulo 2^16.
REQ-014: The FSM SHALL have states IDLE and RUN: IDLE->RUN when fetch_en=1, RUN->IDLE when fetch_en=0; filling occurs only in RUN.
REQ-015: cxrom_addr SHALL equal fill_addr combinationally (registered source, no combinational path from any input).
REQ-016: Legal consume SHALL satisfy consume <= fetch_valid; a legal consume advances head and head_pc by consume and lowers count by consume.
REQ-017: An illegal consume (consume > fetch_valid) SHALL be ignored (no dequeue) and SHALL raise fetch_err for exactly the following cycle.
REQ-018: Fill condition: state RUN and (count - legal_consume) <= 4; when met, the 4 ROM bytes are appended at the tail, fill_addr += 4, and count = count - consume + 4.
REQ-019: Dequeue and fill in the same cycle SHALL both take effect; count never exceeds 8 and never underflows.
REQ-020: pc_ld=1 SHALL take priority over consume and fill in that cycle: count<=0, head_pc<=pc_new, fill_addr<=pc_new, fetch_err<=0, and the ROM word of that cycle is discarded; FSM state is unchanged.
REQ-021: Latency: pc_ld at edge k -> fetch_valid=0 in cycle k+1 -> with RUN, fetch_valid=3 and fetch_data=ROM[pc_new..pc_new+2] after edge k+1.
REQ-022: Wrap-around: fill_addr 0xFFFC + 4 = 0x0000; head_pc 0xFFFE + 3 = 0x0001; the queue pointers wrap modulo 8.
REQ-023: fetch_en falling in mid-stream SHALL preserve queue contents; consumes remain legal in IDLE.

Reset
REQ-024: While rst=1 (asynchronously): state=IDLE, count=0, head=0, head_pc=0, fill_addr=0; outputs cxrom_addr=0x0000, fetch_pc=0x0000, fetch_data=0x000000, fetch_valid=0, fetch_err=0.
REQ-025: Reset asserted mid-operation SHALL discard all queued bytes; after release the first fill is from address 0x0000 once fetch_en=1.

Verification
REQ-026: Reset release, fetch_en=1, consume=0, ROM byte(a)=a[7:0] -> one cycle later fetch_valid=3, fetch_data=0x020100, fetch_pc=0x0000; after the second fill count=8, cxrom_addr=0x0008, and no further fill.
REQ-027: Steady consume=3 each cycle from pc 0x0100 -> fetch_pc advances by 3 per cycle with no bubble, fetch_valid stays 3, fetch_data always equals ROM bytes at fetch_pc.
REQ-028: pc_ld=1, pc_new=0x1234 with consume=2 in the same cycle -> consume ignored, next cycle fetch_valid=0 and cxrom_addr=0x1234, following cycle fetch_pc=0x1234, fetch_valid=3.
REQ-029: pc_ld to 0xFFFC, then consume=3 twice -> cxrom_addr goes 0xFFFC, 0x0000; fetch_pc goes 0xFFFC, 0xFFFF, 0x0002 with correct bytes.
REQ-030: fetch_valid=1 (fetch_en=0), consume=2 -> no dequeue, fetch_err=1 for one cycle, fetch_pc unchanged.
REQ-031: rst pulsed while count=6 and fetch_en=1 -> outputs immediately take their reset values; after release, refill starts at 0x0000.
